// File: rtl/lutram_fifo32.sv
// lutram_fifo32: 32-deep distributed-RAM FIFO with registered output stage; `LUTRAM_FIFO32_WATERMARK_EN adds MAX_LEVEL/WM_CLR
module lutram_fifo32 #(
  parameter int DATA_W = 16,
  parameter int AFULL_THR = 28,
  parameter int AEMPTY_THR = 2,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              CLK,
  input  logic              RSTN,
`ifdef LUTRAM_FIFO32_WATERMARK_EN
  input  logic              WM_CLR,
  output logic [5:0]        MAX_LEVEL,
`endif
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [DATA_W-1:0] S_DATA,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic [DATA_W-1:0] M_DATA,
  output logic [5:0]        LEVEL,
  output logic              ALMOST_FULL,
  output logic              ALMOST_EMPTY
);
  localparam logic [5:0] AF = 6'(AFULL_THR);
  localparam logic [5:0] AE = 6'(AEMPTY_THR);
  logic [DATA_W-1:0] ram [32];
  logic [DATA_W-1:0] head;
  logic [4:0] wr_ptr, rd_ptr;
  logic [5:0] count, count_nx, level_nx;
  logic accept, load, bypass, ram_wr, ram_rd, valid_nx;
  assign LEVEL = count + {5'd0, M_VALID};
  assign S_READY = RSTN & (LEVEL != 6'd33);
  // handshake decode: stage refills from RAM head first, bypasses only when RAM is empty
  always_comb begin
    accept = S_VALID & S_READY;
    load = !M_VALID | M_READY;
    ram_rd = load & (count != 6'd0);
    bypass = accept & load & (count == 6'd0);
    ram_wr = accept & !bypass;
    valid_nx = load ? (ram_rd | bypass) : 1'b1;
    count_nx = count + {5'd0, ram_wr} - {5'd0, ram_rd};
    level_nx = count_nx + {5'd0, valid_nx};
    head = count != 6'd0 ? ram[rd_ptr] : INIT_VAL;
  end
  // storage array: write port only, never reset
  always_ff @(posedge CLK)
    if (ram_wr) ram[wr_ptr] <= S_DATA;
  // pointers, RAM count, output stage and threshold flags
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      M_VALID <= 1'b0;
      M_DATA <= '0;
      ALMOST_FULL <= 1'b0;
      ALMOST_EMPTY <= 1'b1;
    end else begin
      if (ram_wr) wr_ptr <= wr_ptr + 5'd1;
      if (ram_rd) rd_ptr <= rd_ptr + 5'd1;
      count <= count_nx;
      M_VALID <= valid_nx;
      if (load & valid_nx) M_DATA <= ram_rd ? head : S_DATA;
      ALMOST_FULL <= level_nx >= AF;
      ALMOST_EMPTY <= level_nx <= AE;
    end
  end
`ifdef LUTRAM_FIFO32_WATERMARK_EN
  // high-water mark of LEVEL, restartable from the current level
  always_ff @(posedge CLK) begin
    if (!RSTN) MAX_LEVEL <= '0;
    else MAX_LEVEL <= (WM_CLR || level_nx > MAX_LEVEL) ? level_nx : MAX_LEVEL;
  end
`endif
`ifndef SYNTHESIS
  // occupancy sanity
  always_ff @(posedge CLK) begin
    if (RSTN) begin
      assert (LEVEL <= 6'd33);
      assert (count <= 6'd32);
    end
  end
`endif
endmodule
